ffd_test_driver: RTL and testbench

FFD_TEST_DRIVER -- requirements
Module: ffd_test_driver

---
 rtl/ffd_test_driver.sv | 129 ++++++++++++
 tb/tb_ffd_test_driver.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/ffd_test_driver.sv
// rtl/ffd_test_driver.sv - stimulus/compare driver for an evolved D flip-flop
//
// Applies NUM_VECTORS pseudo-random 2-bit stimulus vectors to a candidate
// flip-flop circuit. Each vector is held for SETTLE_CYCLES clocks. The
// synchronized response is then compared against a golden edge-triggered DFF
// model.
//
// Ports:
//   clk        - single clock, all state on rising edge
//   rst        - asynchronous active-high reset
//   start      - level-sampled run request (honoured in IDLE and DONE only)
//   dut_in     - stimulus, bit 0 = D, bit 1 = clock-like strobe
//   dut_out    - candidate response, asynchronous to clk
//   busy       - run in progress
//   done       - run finished, held until next run or reset
//   pass       - valid with done: no mismatches and at least one comparison
//   err_count  - saturating mismatch count
//   vec_index  - index of the vector currently applied

module ffd_test_driver #(
   parameter int SETTLE_CYCLES = 8,
   parameter int NUM_VECTORS   = 64,
   parameter int CNT_W         = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic [1:0]       dut_in,
   input  logic             dut_out,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] vec_index
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] APPLY  = 3'd1;
   localparam logic [2:0] SETTLE = 3'd2;
   localparam logic [2:0] SAMPLE = 3'd3;
   localparam logic [2:0] DONE   = 3'd4;

   localparam logic [7:0]  LFSR_SEED   = 8'hA5;
   localparam logic [7:0]  SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
   // The vector counter is kept at full range independent of CNT_W so a
   // narrow vec_index output cannot stop the run from terminating.
   localparam logic [15:0] LAST_VEC    = 16'(NUM_VECTORS - 1);

   logic [2:0]  state;
   logic [7:0]  lfsr;
   logic        lfsr_fb;
   logic [7:0]  settle_cnt;
   logic [15:0] vec_cnt;
   logic        exp_q;
   logic        armed;
   logic        prev_strobe;
   logic [1:0]  sync_q;

   // x^8 + x^6 + x^5 + x^4 + 1, shifting toward the MSB
   assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         lfsr        <= LFSR_SEED;
         settle_cnt  <= 8'd0;
         vec_cnt     <= 16'd0;
         exp_q       <= 1'b0;
         armed       <= 1'b0;
         prev_strobe <= 1'b0;
         sync_q      <= 2'b00;
         dut_in      <= 2'b00;
         err_count   <= '0;
      end else begin
         sync_q <= {sync_q[0], dut_out};
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state       <= APPLY;
                  lfsr        <= LFSR_SEED;
                  vec_cnt     <= 16'd0;
                  err_count   <= '0;
                  exp_q       <= 1'b0;
                  armed       <= 1'b0;
                  // dut_in may still hold a high strobe from the last run;
                  // the golden model treats each run as starting from low.
                  prev_strobe <= 1'b0;
               end
            end
            APPLY: begin
               dut_in <= lfsr[1:0];
               if (!prev_strobe && lfsr[1]) begin
                  exp_q <= lfsr[0];
                  armed <= 1'b1;
               end
               prev_strobe <= lfsr[1];
               settle_cnt  <= SETTLE_LOAD;
               state       <= SETTLE;
            end
            SETTLE: begin
               if (settle_cnt == 8'd0) begin
                  state <= SAMPLE;
               end else begin
                  settle_cnt <= settle_cnt - 8'd1;
               end
            end
            SAMPLE: begin
               if (armed && (sync_q[1] != exp_q) && (err_count != '1)) begin
                  err_count <= err_count + CNT_W'(1);
               end
               lfsr <= {lfsr[6:0], lfsr_fb};
               if (vec_cnt == LAST_VEC) begin
                  state <= DONE;
               end else begin
                  vec_cnt <= vec_cnt + 16'd1;
                  state   <= APPLY;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy      = (state == APPLY) || (state == SETTLE) || (state == SAMPLE);
   assign done      = (state == DONE);
   assign pass      = done && (err_count == '0) && armed;
   assign vec_index = CNT_W'(vec_cnt);

endmodule

// File: tb/tb_ffd_test_driver.sv
// tb/tb_ffd_test_driver.sv - self-checking bench for ffd_test_driver

module tb_ffd_test_driver;

   localparam int S     = 8;
   localparam int N     = 64;
   localparam int PER   = S + 2;
   localparam int LIMIT = 2000;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  dut_in;
   logic        dut_out;
   logic        busy, done, pass;
   logic [15:0] err_count, vec_index;

   logic        start2;
   logic [1:0]  dut_in2;
   logic        dut_out2;
   logic        busy2, done2, pass2;
   logic [2:0]  err2, vidx2;

   int mode;
   int passed = 0;
   int total  = 0;

   logic ff_q  = 1'b0;
   logic ff2_q = 1'b0;

   logic [1:0] stim [N];

   always #5 clk = ~clk;

   ffd_test_driver #(.SETTLE_CYCLES(S), .NUM_VECTORS(N), .CNT_W(16)) u_dut (
      .clk(clk), .rst(rst), .start(start), .dut_in(dut_in), .dut_out(dut_out),
      .busy(busy), .done(done), .pass(pass), .err_count(err_count), .vec_index(vec_index)
   );

   ffd_test_driver #(.SETTLE_CYCLES(S), .NUM_VECTORS(N), .CNT_W(3)) u_sat (
      .clk(clk), .rst(rst), .start(start2), .dut_in(dut_in2), .dut_out(dut_out2),
      .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .vec_index(vidx2)
   );

   // Ideal behavioural flip-flops standing in for the evolved circuit
   always @(posedge dut_in[1])  ff_q  = dut_in[0];
   always @(posedge dut_in2[1]) ff2_q = dut_in2[0];

   assign dut_out  = (mode == 0) ? ff_q : (mode == 1) ? ~ff_q : 1'b0;
   assign dut_out2 = ~ff2_q;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Stimulus table from the LFSR rule: seed A5, one shift per vector
   function automatic void build_stim();
      logic [7:0] x;
      x = 8'hA5;
      for (int k = 0; k < N; k++) begin
         stim[k] = x[1:0];
         x = {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
      end
   endfunction

   // Expected mismatch count: mode 0 ideal, 1 inverted, 2 tied low
   function automatic void model_run(input int m, input int cap, output int e, output bit arm);
      bit prev, ex;
      prev = 0; ex = 0; arm = 0; e = 0;
      for (int k = 0; k < N; k++) begin
         if (!prev && stim[k][1]) begin
            ex  = stim[k][0];
            arm = 1;
         end
         prev = stim[k][1];
         if (arm && ((m == 1) || (m == 2 && ex)) && e < cap) e++;
      end
   endfunction

   task automatic do_run(input int m, input string tag);
      int n, bad, k, e;
      bit arm;
      mode  = m;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, "_busy_start"}, 32'(busy), 32'd1);
      check({tag, "_err_clear"},  32'(err_count), 32'd0);
      check({tag, "_done_clear"}, 32'(done), 32'd0);
      n = 0; bad = 0;
      while (n < LIMIT) begin
         k = (n / PER < N) ? n / PER : N - 1;
         if (vec_index !== 16'(k) || busy !== (n < N * PER)) bad++;
         if (n > 0) begin
            k = ((n - 1) / PER < N) ? (n - 1) / PER : N - 1;
            if (dut_in !== stim[k]) bad++;
         end
         if (done) break;
         start = ($urandom_range(0, 15) == 0);
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      model_run(m, 65535, e, arm);
      check({tag, "_len"},  32'(n), 32'(N * PER));
      check({tag, "_seq"},  32'(bad), 32'd0);
      check({tag, "_err"},  32'(err_count), 32'(e));
      check({tag, "_pass"}, 32'(pass), 32'(arm && e == 0));
      check({tag, "_vidx"}, 32'(vec_index), 32'(N - 1));
      check({tag, "_busy_end"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int n, wraps, e;
      logic [2:0] prev_err;
      bit arm;
      build_stim();
      mode = 0; rst = 1'b1; start = 1'b1; start2 = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_dut_in", 32'(dut_in), 32'd0);
      check("rst_busy",   32'(busy), 32'd0);
      check("rst_done",   32'(done), 32'd0);
      check("rst_pass",   32'(pass), 32'd0);
      check("rst_err",    32'(err_count), 32'd0);
      check("rst_vidx",   32'(vec_index), 32'd0);
      rst = 1'b0;
      check("start_in_rst_idle", 32'(busy), 32'd0);
      do_run(0, "ideal");

      repeat ($urandom_range(1, 6)) @(negedge clk);
      check("done_hold", 32'(done), 32'd1);
      do_run(1, "inverted");
      do_run(2, "tied0");

      // Abort an inverted run part-way with an asynchronous reset
      mode  = 1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (99) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("abort_dut_in", 32'(dut_in), 32'd0);
      check("abort_busy",   32'(busy), 32'd0);
      check("abort_done",   32'(done), 32'd0);
      check("abort_pass",   32'(pass), 32'd0);
      check("abort_err",    32'(err_count), 32'd0);
      check("abort_vidx",   32'(vec_index), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat ($urandom_range(2, 8)) @(negedge clk);
      check("abort_needs_start", 32'(busy), 32'd0);
      do_run(0, "rerun");

      // Narrow counter instance with an inverted response
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      n = 0; wraps = 0; prev_err = 3'd0;
      while (!done2 && n < LIMIT) begin
         @(negedge clk);
         n++;
         if (err2 < prev_err) wraps++;
         prev_err = err2;
      end
      model_run(1, 7, e, arm);
      check("sat_len",   32'(n), 32'(N * PER));
      check("sat_err",   32'(err2), 32'(e));
      check("sat_wrap",  32'(wraps), 32'd0);
      check("sat_pass",  32'(pass2), 32'd0);
      check("sat_vidx",  32'(vidx2), 32'((N - 1) % 8));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
